sram_seq_ctrl: RTL and testbench



---
 rtl/sram_seq_ctrl.sv | 115 +++++++++++
 tb/tb_sram_seq_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sram_seq_ctrl.sv
// sram_seq_ctrl: sequences single-word SRAM reads/writes into registered wordline, precharge and sense-amp controls.
module sram_seq_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int COLS      = 1,
    parameter int PRE_CYC   = 2,
    parameter int WL_CYC    = 2,
    parameter int SENSE_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [COLS-1:0]      req_wdata,
    output logic                 rsp_valid,
    output logic [COLS-1:0]      rsp_rdata,
    output logic [2**ADDR_W-1:0] row,
    output logic                 rd_wr,
    output logic [COLS-1:0]      data_in,
    output logic                 pre_en,
    output logic                 sa_en,
    input  logic [COLS-1:0]      preout
);
    localparam int ROWS    = 2**ADDR_W;
    localparam int MAX_CYC = PRE_CYC > WL_CYC ? (PRE_CYC > SENSE_CYC ? PRE_CYC : SENSE_CYC)
                                              : (WL_CYC > SENSE_CYC ? WL_CYC : SENSE_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {IDLE, SETUP, PRE, WL, SENSE, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COLS-1:0]   wdata_q, wdata_d;
    logic [COLS-1:0]   rdata_q, rdata_d;
    logic              ready_d, valid_d, rd_wr_d, pre_en_d, sa_en_d;
    logic [ROWS-1:0]   row_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = SETUP;
                we_d    = req_we;
                addr_d  = req_addr;
                wdata_d = req_wdata;
            end
            SETUP: begin
                state_d = we_q ? WL : PRE;
                cnt_d   = we_q ? CNT_W'(WL_CYC - 1) : CNT_W'(PRE_CYC - 1);
            end
            PRE: begin
                state_d = cnt_q == '0 ? WL : PRE;
                cnt_d   = cnt_q == '0 ? CNT_W'(WL_CYC - 1) : cnt_q - CNT_W'(1);
            end
            WL: begin
                state_d = cnt_q != '0 ? WL : (we_q ? DONE : SENSE);
                cnt_d   = cnt_q == '0 ? CNT_W'(SENSE_CYC - 1) : cnt_q - CNT_W'(1);
            end
            SENSE: begin
                state_d = cnt_q == '0 ? DONE : SENSE;
                cnt_d   = cnt_q - CNT_W'(1);
                rdata_d = cnt_q == '0 ? preout : rdata_q;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so every array control leaves a flop.
        ready_d  = state_d == IDLE;
        valid_d  = state_d == DONE;
        row_d    = state_d == WL ? ROWS'(1) << addr_d : '0;
        rd_wr_d  = (state_d == SETUP || state_d == WL) ? ~we_d : (state_d == PRE || state_d == SENSE);
        pre_en_d = state_d == IDLE || state_d == DONE || state_d == PRE || (state_d == SETUP && !we_d);
        sa_en_d  = state_d == SENSE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            row       <= '0;
            rd_wr     <= 1'b0;
            pre_en    <= 1'b1;
            sa_en     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            req_ready <= ready_d;
            rsp_valid <= valid_d;
            row       <= row_d;
            rd_wr     <= rd_wr_d;
            pre_en    <= pre_en_d;
            sa_en     <= sa_en_d;
        end
    end

    assign data_in   = wdata_q;
    assign rsp_rdata = rdata_q;
endmodule

// File: tb/tb_sram_seq_ctrl.sv
// tb_sram_seq_ctrl: directed bench for sram_seq_ctrl at default parameters plus a short-address, long-timing variant.
module tb_sram_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_ready, rsp_valid, rd_wr, pre_en, sa_en;
    logic [3:0]  req_addr = '0;
    logic [0:0]  req_wdata = '0, rsp_rdata, data_in, preout = '0;
    logic [15:0] row;
    logic        req_valid2 = 1'b0, req_we2 = 1'b0, req_ready2, rsp_valid2, rd_wr2, pre_en2, sa_en2;
    logic [1:0]  req_addr2 = '0;
    logic [0:0]  req_wdata2 = '0, rsp_rdata2, data_in2, preout2 = '0;
    logic [3:0]  row2;
    int          checks = 0, failures = 0;

    sram_seq_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .row(row), .rd_wr(rd_wr), .data_in(data_in), .pre_en(pre_en), .sa_en(sa_en), .preout(preout)
    );

    sram_seq_ctrl #(.ADDR_W(2), .COLS(1), .PRE_CYC(1), .WL_CYC(4), .SENSE_CYC(3)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
        .req_addr(req_addr2), .req_wdata(req_wdata2), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
        .row(row2), .rd_wr(rd_wr2), .data_in(data_in2), .pre_en(pre_en2), .sa_en(sa_en2), .preout(preout2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic rdy, input logic vld, input logic [15:0] rw,
                       input logic rdwr, input logic pe, input logic se, input logic di);
        chk({tag, ".ready"}, req_ready, rdy);
        chk({tag, ".valid"}, rsp_valid, vld);
        chk({tag, ".row"}, row, rw);
        chk({tag, ".rd_wr"}, rd_wr, rdwr);
        chk({tag, ".pre_en"}, pre_en, pe);
        chk({tag, ".sa_en"}, sa_en, se);
        chk({tag, ".data_in"}, data_in, di);
    endtask

    task automatic issue(input logic we, input logic [3:0] addr, input logic wd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wordline exclusivity is checked on every cycle for both instances.
    always @(negedge clk) if (!rst) begin
        chk("overlap", {31'd0, |row && (pre_en || sa_en)}, 0);
        chk("onehot", {31'd0, $onehot0(row)}, 1);
        chk("overlap2", {31'd0, |row2 && (pre_en2 || sa_en2)}, 0);
        chk("onehot2", {31'd0, $onehot0(row2)}, 1);
    end

    initial begin
        int   n, last, e, wl_hits, bad_rows;
        logic prev_we, acc, seen;
        repeat (2) @(negedge clk);
        cyc("rst", 1, 0, 16'h0, 0, 1, 0, 0);
        chk("rst.rdata", rsp_rdata, 0);
        chk("rst2.ready", req_ready2, 1);
        chk("rst2.pre_en", pre_en2, 1);
        rst = 1'b0;
        @(negedge clk);

        issue(1, 3, 1);
        cyc("w1.setup", 0, 0, 16'h0, 0, 0, 0, 1);
        @(negedge clk); cyc("w1.wl1", 0, 0, 16'h8, 0, 0, 0, 1);
        @(negedge clk); cyc("w1.wl2", 0, 0, 16'h8, 0, 0, 0, 1);
        @(negedge clk); cyc("w1.done", 0, 1, 16'h0, 0, 1, 0, 1);
        chk("w1.rdata", rsp_rdata, 0);
        @(negedge clk); cyc("w1.idle", 1, 0, 16'h0, 0, 1, 0, 1);

        preout = 1'b1;
        issue(0, 3, 0);
        cyc("r1.setup", 0, 0, 16'h0, 1, 1, 0, 0);
        @(negedge clk); cyc("r1.pre1", 0, 0, 16'h0, 1, 1, 0, 0);
        @(negedge clk); cyc("r1.pre2", 0, 0, 16'h0, 1, 1, 0, 0);
        @(negedge clk); cyc("r1.wl1", 0, 0, 16'h8, 1, 0, 0, 0);
        @(negedge clk); cyc("r1.wl2", 0, 0, 16'h8, 1, 0, 0, 0);
        @(negedge clk); cyc("r1.sense", 0, 0, 16'h0, 1, 0, 1, 0);
        @(negedge clk); cyc("r1.done", 0, 1, 16'h0, 0, 1, 0, 0);
        chk("r1.rdata", rsp_rdata, 1);
        @(negedge clk); cyc("r1.idle", 1, 0, 16'h0, 0, 1, 0, 0);

        issue(1, 3, 0);
        repeat (4) @(negedge clk);
        preout = 1'b0;
        issue(0, 3, 0);
        repeat (6) @(negedge clk);
        chk("r2.valid", rsp_valid, 1);
        chk("r2.rdata", rsp_rdata, 0);
        @(negedge clk);
        preout = 1'b1;
        issue(1, 5, 1);
        @(negedge clk); chk("w3.row", row, 16'h20);
        repeat (2) @(negedge clk);
        chk("w3.valid", rsp_valid, 1);
        chk("w3.rdata", rsp_rdata, 0);
        @(negedge clk);

        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd6;
        n = 0; last = 0; prev_we = 1'b0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            acc = req_ready;
            if (acc) begin
                if (n > 0) chk("spacing", c - last, prev_we ? 5 : 8);
                last = c; prev_we = req_we; n++;
            end
            @(negedge clk);
            if (acc) req_we = ~req_we;
        end
        chk("accepts", n, 4);
        req_valid = 1'b0;
        for (int c = 0; c < 20 && !req_ready; c++) @(negedge clk);
        chk("drain.ready", req_ready, 1);
        chk("drain.rdata", rsp_rdata, 1);

        issue(0, 3, 0);
        repeat (4) @(negedge clk);
        chk("abort.wl2", row, 16'h8);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.row", row, 0);
        chk("abort.sa_en", sa_en, 0);
        chk("abort.pre_en", pre_en, 1);
        chk("abort.ready", req_ready, 1);
        chk("abort.rdata", rsp_rdata, 0);
        rst = 1'b0;
        seen = rsp_valid;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            seen |= rsp_valid;
        end
        chk("abort.no_rsp", seen, 0);
        chk("abort.rdata_after", rsp_rdata, 0);

        preout2   = 1'b1;
        req_valid2 = 1'b1; req_we2 = 1'b0; req_addr2 = 2'b11;
        @(negedge clk);
        req_valid2 = 1'b0;
        e = 0; wl_hits = 0; bad_rows = 0;
        while (!rsp_valid2 && e < 20) begin
            @(negedge clk);
            e++;
            wl_hits  += int'(row2 == 4'b1000);
            bad_rows += int'(row2 != 4'b0000 && row2 != 4'b1000);
        end
        chk("sweep.latency", e, 9);
        chk("sweep.wl_cycles", wl_hits, 4);
        chk("sweep.bad_rows", bad_rows, 0);
        chk("sweep.rdata", rsp_rdata2, 1);
        @(negedge clk);
        chk("sweep.idle", req_ready2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
